// File: rtl/spram_pkg.sv
// Shared types and constants for the byte-enable single-port RAM with clear sweep.
package spram_pkg;

  typedef enum logic {ST_IDLE, ST_CLEAR} state;

  localparam int RDW_NEW = 0;
  localparam int RDW_OLD = 1;

endpackage

// File: rtl/spram_core.sv
// Raw word array with per-lane write enables and one registered read port.
// The read register only loads on rd_en, so it holds its value otherwise.
module spram_core
  import spram_pkg::*;
#(
  parameter int AW        = 10,
  parameter int W         = 8,
  parameter int BW        = 8,
  parameter int RDW       = RDW_NEW,
  parameter     INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             rd_en,
  input  logic [W/BW-1:0]  we,
  input  logic [AW-1:0]    addr,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata
);

  localparam int NB    = W / BW;
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] old_word;
  logic [W-1:0] merged_word;
  logic [W-1:0] rdata_q;
  logic [W-1:0] rdata_d;

  always_comb begin
    old_word    = mem[addr];
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) merged_word[i*BW +: BW] = wdata[i*BW +: BW];
    end
    rdata_d = rdata_q;
    if (rd_en) rdata_d = (RDW == RDW_OLD) ? old_word : merged_word;
  end

  // Lanes are written individually so untouched bytes keep their contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[addr][i*BW +: BW] <= wdata[i*BW +: BW];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spramv_be_clr.sv
// Single-port RAM with byte enables, selectable read-during-write result,
// 1/2-cycle read pipeline with valid strobe and a post-reset clear sweep.
module spramv_be_clr
  import spram_pkg::*;
#(
  parameter int                 widthad_a      = 10,
  parameter int                 width_a        = 8,
  parameter int                 byte_w         = 8,
  parameter int                 rd_lat         = 1,
  parameter int                 rdw_mode       = RDW_NEW,
  parameter int                 clear_on_reset = 1,
  parameter logic [width_a-1:0] clear_value    = '0,
  parameter                     init_file      = ""
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cs,
  input  logic                        wren,
  input  logic [width_a/byte_w-1:0]   be,
  input  logic [widthad_a-1:0]        address,
  input  logic [width_a-1:0]          data,
  output logic [width_a-1:0]          q,
  output logic                        q_valid,
  output logic                        busy
);

  localparam int NB = width_a / byte_w;
  localparam logic [widthad_a-1:0] CNT_LAST = '1;

  if (width_a % byte_w != 0) begin : g_bad_width
    $error("spramv_be_clr: width_a must be a multiple of byte_w");
  end
  if (rd_lat != 1 && rd_lat != 2) begin : g_bad_lat
    $error("spramv_be_clr: rd_lat must be 1 or 2");
  end

  state                 state_q, state_d;
  logic [widthad_a-1:0] cnt_q, cnt_d;
  logic                 access;
  logic [widthad_a-1:0] mem_addr;
  logic [NB-1:0]        mem_we;
  logic [width_a-1:0]   mem_wdata;
  logic [width_a-1:0]   core_rdata;
  logic                 v1_q, v1_d;

  assign busy   = (state_q == ST_CLEAR);
  assign access = cs && !busy && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= (clear_on_reset != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep owns the array port while busy; user requests are dropped.
  always_comb begin
    mem_addr  = address;
    mem_wdata = data;
    mem_we    = (access && wren) ? be : '0;
    if (busy) begin
      mem_addr  = cnt_q;
      mem_wdata = clear_value;
      mem_we    = '1;
    end
  end

  spram_core #(
    .AW        (widthad_a),
    .W         (width_a),
    .BW        (byte_w),
    .RDW       (rdw_mode),
    .INIT_FILE (init_file)
  ) u_core (
    .clk   (clock),
    .srst  (reset),
    .rd_en (access),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (core_rdata)
  );

  assign v1_d = access;

  always_ff @(posedge clock) begin
    if (reset) v1_q <= 1'b0;
    else       v1_q <= v1_d;
  end

  if (rd_lat == 2) begin : g_lat2
    logic [width_a-1:0] q2_q, q2_d;
    logic               v2_q, v2_d;

    always_comb begin
      q2_d = q2_q;
      v2_d = v1_q;
      if (v1_q) q2_d = core_rdata;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        q2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        q2_q <= q2_d;
        v2_q <= v2_d;
      end
    end

    assign q       = q2_q;
    assign q_valid = v2_q;
  end else begin : g_lat1
    assign q       = core_rdata;
    assign q_valid = v1_q;
  end

endmodule

// File: tb/tb_spramv_be_clr.sv
// Directed bench: four RAM variants share one stimulus stream; outputs checked against hand values.
module tb_spramv_be_clr;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs;
  logic        wren;
  logic [1:0]  be;
  logic [3:0]  address;
  logic [15:0] data;

  logic [15:0] q_a, q_b, q_c, q_d;
  logic        qv_a, qv_b, qv_c, qv_d;
  logic        busy_a, busy_b, busy_c, busy_d;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  // a: lat1/new-data, b: lat1/old-data, c: lat2/new-data, d: no clear sweep
  spramv_be_clr #(.widthad_a(4), .width_a(16), .byte_w(8), .rd_lat(1), .rdw_mode(0),
                  .clear_on_reset(1), .clear_value(16'hA5A5)) u_a (
    .clock(clock), .reset(reset), .cs(cs), .wren(wren), .be(be), .address(address),
    .data(data), .q(q_a), .q_valid(qv_a), .busy(busy_a));

  spramv_be_clr #(.widthad_a(4), .width_a(16), .byte_w(8), .rd_lat(1), .rdw_mode(1),
                  .clear_on_reset(1), .clear_value(16'hA5A5)) u_b (
    .clock(clock), .reset(reset), .cs(cs), .wren(wren), .be(be), .address(address),
    .data(data), .q(q_b), .q_valid(qv_b), .busy(busy_b));

  spramv_be_clr #(.widthad_a(4), .width_a(16), .byte_w(8), .rd_lat(2), .rdw_mode(0),
                  .clear_on_reset(1), .clear_value(16'hA5A5)) u_c (
    .clock(clock), .reset(reset), .cs(cs), .wren(wren), .be(be), .address(address),
    .data(data), .q(q_c), .q_valid(qv_c), .busy(busy_c));

  spramv_be_clr #(.widthad_a(4), .width_a(16), .byte_w(8), .rd_lat(1), .rdw_mode(0),
                  .clear_on_reset(0), .clear_value(16'hA5A5)) u_d (
    .clock(clock), .reset(reset), .cs(cs), .wren(wren), .be(be), .address(address),
    .data(data), .q(q_d), .q_valid(qv_d), .busy(busy_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Apply one cycle of inputs, then wait to the next falling edge to sample.
  task automatic drive(input logic c, input logic w, input logic [1:0] b,
                       input logic [3:0] a, input logic [15:0] d);
    cs = c; wren = w; be = b; address = a; data = d;
    @(negedge clock);
  endtask

  initial begin
    int n;
    int n_dbusy;

    reset = 1'b1; cs = 1'b0; wren = 1'b0; be = 2'b00; address = '0; data = '0;
    @(negedge clock);
    @(negedge clock);
    check("rst_q_a", q_a, 16'h0);
    check("rst_qv_a", qv_a, 1'b0);
    check("rst_busy_a", busy_a, 1'b1);
    check("rst_busy_d", busy_d, 1'b0);
    check("rst_q_d", q_d, 16'h0);

    // Sweep length: busy must read high on exactly 16 samples after release.
    reset = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    end
    check("sweep_len", n, 16);
    check("sweep_q_hold", q_a, 16'h0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 2'b11, i[3:0], 16'h0);
      check($sformatf("clr_rd_%0d", i), {qv_a, q_a}, {1'b1, 16'hA5A5});
    end
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    check("idle_qv", {qv_a, q_a}, {1'b0, 16'hA5A5});

    // Byte-enable merge
    drive(1'b1, 1'b1, 2'b11, 4'd3, 16'h1234);
    drive(1'b1, 1'b1, 2'b10, 4'd3, 16'hFF00);
    check("be_wr_new", q_a, 16'hFF34);
    check("be_wr_old", q_b, 16'h1234);
    drive(1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    check("be_rd", q_a, 16'hFF34);

    // Read-during-write result selection
    drive(1'b1, 1'b1, 2'b11, 4'd7, 16'h1111);
    drive(1'b1, 1'b1, 2'b01, 4'd7, 16'h2222);
    check("rdw_new", q_a, 16'h1122);
    check("rdw_old", q_b, 16'h1111);
    drive(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
    check("rdw_old_mem", q_b, 16'h1122);

    // Write with no lanes enabled returns the stored word and changes nothing
    drive(1'b1, 1'b1, 2'b00, 4'd7, 16'hFFFF);
    check("be0_new", {qv_a, q_a}, {1'b1, 16'h1122});
    check("be0_old", q_b, 16'h1122);
    drive(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
    check("be0_rd", q_a, 16'h1122);

    // Two-stage pipeline: preload 0..3, drain, then stream four reads
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 2'b11, i[3:0], i[15:0]);
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    check("lat2_idle", qv_c, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, 1'b0, 2'b00, k[3:0], 16'h0);
      else       drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
      check($sformatf("lat2_qv_%0d", k), qv_c, (k >= 1 && k <= 4) ? 1'b1 : 1'b0);
      if (k >= 1 && k <= 4) check($sformatf("lat2_q_%0d", k), q_c, k - 1);
      check($sformatf("lat1_qv_%0d", k), qv_a, (k < 4) ? 1'b1 : 1'b0);
    end

    // Reset in the middle of a sweep restarts it from zero
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    check("mid_busy", busy_a, 1'b1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    check("rerst_q_a", q_a, 16'h0);
    check("rerst_q_c", q_c, 16'h0);
    reset = 1'b0;
    n = 0;
    n_dbusy = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      if (qv_a !== 1'b0) check($sformatf("busy_qv_%0d", n), qv_a, 1'b0);
      if (busy_d !== 1'b0) n_dbusy++;
      drive(1'b1, 1'b1, 2'b11, 4'd0, 16'h0000);
    end
    check("resweep_len", n, 16);
    check("busy_d_never", n_dbusy, 0);
    check("busy_q_hold", {qv_a, q_a}, {1'b0, 16'h0});
    drive(1'b1, 1'b0, 2'b00, 4'd0, 16'h0);
    check("busy_wr_dropped", q_a, 16'hA5A5);

    // Without a clear sweep, reset leaves contents untouched
    drive(1'b1, 1'b0, 2'b00, 4'd7, 16'h0);
    check("noclr_keep", {qv_d, q_d}, {1'b1, 16'h1122});
    check("clr_wiped", q_a, 16'hA5A5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
